// File: rtl/apb_csr_sequencer.sv
// APB3 slave front end and FIFO launch sequencer for the ALU CSR block.
// A bus FSM decodes transfers; an independent launch FSM pushes FIFO_IN.
module apb_csr_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int APB_BUS_SIZE = 32,
    parameter int RES_WIDTH    = 25,
    parameter int WAIT_LIMIT   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pready,
    output logic                    pslverr,
    output logic [APB_BUS_SIZE-1:0] prdata,
    output logic                    en_ctrl,
    output logic                    en_data0,
    output logic                    en_data1,
    output logic                    w_en_in,
    output logic                    r_en_out,
    output logic                    out_pop,
    input  logic                    start_bit,
    input  logic                    in_full,
    input  logic                    out_empty,
    input  logic [RES_WIDTH-1:0]    final_result,
    input  logic [RES_WIDTH-1:0]    fifo_out_status
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, WR, RD_CAPT, RD_DONE} bus_state_t;
    typedef enum logic [1:0] {L_IDLE, L_WAIT, L_PUSH, L_COOL} launch_state_t;

    bus_state_t    state_q, state_d;
    launch_state_t lstate_q, lstate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] word_q, word_d;

    logic is_ctrl, is_data0, is_data1, is_result, is_status;
    logic is_wmap, busy;

    // Address is latched in the setup phase so decode never sees paddr live.
    assign is_ctrl   = (word_q == WW'(0));
    assign is_data0  = (word_q == WW'(1));
    assign is_data1  = (word_q == WW'(2));
    assign is_result = (word_q == WW'(3));
    assign is_status = (word_q == WW'(4));
    assign is_wmap   = is_ctrl | is_data0 | is_data1;

    assign busy = (lstate_q != L_IDLE) | start_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lstate_q <= L_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            lstate_q <= lstate_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        word_d   = word_q;
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        en_ctrl  = 1'b0;
        en_data0 = 1'b0;
        en_data1 = 1'b0;
        out_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    word_d  = paddr[ADDR_WIDTH-1:2];
                    state_d = pwrite ? WR : RD_CAPT;
                end
            end
            WR: begin
                state_d = IDLE;
                if (!psel) begin
                end else if (!is_wmap) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end else if (!busy) begin
                    pready   = 1'b1;
                    en_ctrl  = is_ctrl;
                    en_data0 = is_data0;
                    en_data1 = is_data1;
                end else if (cnt_q == CW'(WAIT_LIMIT)) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WR;
                end
            end
            RD_CAPT: begin
                state_d = IDLE;
                if (!psel) begin
                end else if (is_result) begin
                    if (out_empty) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else begin
                        state_d = RD_DONE;
                    end
                end else if (is_status) begin
                    pready = 1'b1;
                    prdata = APB_BUS_SIZE'(fifo_out_status);
                end else begin
                    pready  = 1'b1;
                    pslverr = !is_wmap;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
                if (psel) begin
                    pready  = 1'b1;
                    out_pop = 1'b1;
                    prdata  = APB_BUS_SIZE'(final_result);
                end
            end
        endcase
    end

    assign r_en_out = ((state_q == RD_CAPT) && is_result)
                    || (state_q == RD_DONE);

    // L_COOL gives the CTRL start bit a cycle to clear after the push.
    always_comb begin
        lstate_d = lstate_q;
        unique case (lstate_q)
            L_IDLE: if (start_bit) lstate_d = L_WAIT;
            L_WAIT: if (!in_full)  lstate_d = L_PUSH;
            L_PUSH: lstate_d = L_COOL;
            L_COOL: lstate_d = L_IDLE;
        endcase
    end

    assign w_en_in = (lstate_q == L_PUSH);

endmodule

// File: tb/tb_apb_csr_sequencer.sv
// Scoreboard bench for apb_csr_sequencer with CTRL, FIFO_OUT and RESULT models.
// Expected transfer outcomes are queued at issue and compared at completion.
module tb_apb_csr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        en_ctrl, en_data0, en_data1;
    logic        w_en_in, r_en_out, out_pop;
    logic        start_bit, in_full, out_empty;
    logic [24:0] final_result, fifo_out_status, fifo_head;

    int n_chk, n_pass;
    int cyc;
    int n_ctrl, n_d0, n_d1, n_push, n_pop, n_loaded;
    int rise_cyc, push_cyc;
    logic start_prev;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          waits;
        string       tag;
    } exp_t;

    exp_t sb[$];

    apb_csr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr),
        .pready(pready), .pslverr(pslverr),
        .prdata(prdata),
        .en_ctrl(en_ctrl), .en_data0(en_data0),
        .en_data1(en_data1),
        .w_en_in(w_en_in), .r_en_out(r_en_out),
        .out_pop(out_pop),
        .start_bit(start_bit), .in_full(in_full),
        .out_empty(out_empty),
        .final_result(final_result),
        .fifo_out_status(fifo_out_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // CTRL start bit: set by a CTRL write, self-cleared by the push.
    // RESULT register: captures the FIFO_OUT head while r_en_out is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_bit    <= 1'b0;
            final_result <= '0;
        end else begin
            if (en_ctrl)      start_bit <= 1'b1;
            else if (w_en_in) start_bit <= 1'b0;
            final_result <= r_en_out ? fifo_head : '0;
        end
    end

    assign out_empty = (n_loaded <= n_pop);

    always @(negedge clk) begin
        n_ctrl += int'(en_ctrl);
        n_d0   += int'(en_data0);
        n_d1   += int'(en_data1);
        n_push += int'(w_en_in);
        n_pop  += int'(out_pop);
        if (w_en_in) push_cyc = cyc;
        if (start_bit && !start_prev) rise_cyc = cyc;
        start_prev = start_bit;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h",
                      tag, got, exp);
    endtask

    task automatic apb(input logic wr, input logic [7:0] addr,
                       output logic [31:0] rd, output logic err,
                       output int waits);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!pready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        rd  = prdata;
        err = pslverr;
        if (!pready) check("apb_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr,
                        input logic [7:0] addr,
                        input logic [31:0] erd, input logic eerr,
                        input int ewaits);
        exp_t e;
        logic [31:0] rd;
        logic err;
        int w;
        sb.push_back('{erd, eerr, ewaits, tag});
        apb(wr, addr, rd, err, w);
        e = sb.pop_front();
        check({e.tag, ".rdata"}, rd, e.rd);
        check({e.tag, ".err"}, 32'(err), 32'(e.err));
        check({e.tag, ".waits"}, 32'(w), 32'(e.waits));
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, pready, pslverr, en_ctrl, en_data0,
                en_data1, w_en_in, r_en_out, out_pop};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int p0, e0;
        n_chk = 0; n_pass = 0; cyc = 0;
        n_ctrl = 0; n_d0 = 0; n_d1 = 0;
        n_push = 0; n_pop = 0; n_loaded = 0;
        rise_cyc = 0; push_cyc = 0; start_prev = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0;
        in_full = 0;
        fifo_head = '0; fifo_out_status = '0;
        rst_n = 1'b0;
        #1;
        check("reset.outs", outs(), 32'd0);
        check("reset.prdata", prdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer("wr_d0", 1'b1, 8'h04, 32'd0, 1'b0, 0);
        xfer("wr_d1", 1'b1, 8'h08, 32'd0, 1'b0, 0);
        xfer("wr_ctrl", 1'b1, 8'h00, 32'd0, 1'b0, 0);
        repeat (8) @(negedge clk);
        check("en_d0.cnt", n_d0, 1);
        check("en_d1.cnt", n_d1, 1);
        check("en_ctrl.cnt", n_ctrl, 1);
        check("push.cnt", n_push, 1);
        check("push.lat", push_cyc - rise_cyc, 2);

        in_full = 1'b1;
        p0 = n_push;
        xfer("full_ctrl", 1'b1, 8'h00, 32'd0, 1'b0, 0);
        fork
            begin
                repeat (10) @(negedge clk);
                check("full.nopush", n_push, p0);
                in_full = 1'b0;
            end
            xfer("stall_d0", 1'b1, 8'h04, 32'd0, 1'b0, 11);
        join
        repeat (4) @(negedge clk);
        check("full.push", n_push, p0 + 1);
        check("stall_d0.cnt", n_d0, 2);

        in_full = 1'b1;
        p0 = n_push;
        xfer("to_ctrl", 1'b1, 8'h00, 32'd0, 1'b0, 0);
        xfer("to_d0", 1'b1, 8'h04, 32'd0, 1'b1, 16);
        check("to_d0.noen", n_d0, 2);
        in_full = 1'b0;
        repeat (6) @(negedge clk);
        check("to.push", n_push, p0 + 1);

        fifo_head = 25'h0ABCDEF;
        n_loaded = 1;
        xfer("rd_res", 1'b0, 8'h0C, 32'h0ABCDEF, 1'b0, 1);
        check("rd_res.pop", n_pop, 1);
        xfer("rd_empty", 1'b0, 8'h0C, 32'd0, 1'b1, 0);
        check("rd_empty.pop", n_pop, 1);

        fifo_out_status = 25'h2;
        xfer("rd_stat", 1'b0, 8'h10, 32'h2, 1'b0, 0);
        xfer("rd_ctrl", 1'b0, 8'h00, 32'd0, 1'b0, 0);
        e0 = n_ctrl + n_d0 + n_d1;
        xfer("wr_bad", 1'b1, 8'h14, 32'd0, 1'b1, 0);
        xfer("rd_bad", 1'b0, 8'h14, 32'd0, 1'b1, 0);
        check("wr_bad.noen", n_ctrl + n_d0 + n_d1, e0);

        in_full = 1'b1;
        p0 = n_push;
        xfer("rst_ctrl", 1'b1, 8'h00, 32'd0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait.outs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_full = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_wait.push", n_push, p0);

        n_loaded = n_pop + 1;
        p0 = n_pop;
        psel = 1'b1; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h0C;
        @(negedge clk);
        penable = 1'b1;
        check("rd_capt.ren", 32'(r_en_out), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_capt.outs", outs(), 32'd0);
        check("rst_capt.prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_capt.pop", n_pop, p0);
        check("rst_capt.idle", outs(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
